// File: rtl/popcnt_arbiter.sv
// popcnt_arbiter: round-robin share of one external popcount engine.
// Ports: clk_i, arst_n_i (async active-low);
//   req_data_i/req_val_i/req_ready_o : N_REQ client words (k at [k*WIDTH+:WIDTH]);
//   pc_data_o/pc_data_val_o : word + 1-cycle valid pulse to the engine;
//   pc_data_i/pc_data_val_i : count back from the engine;
//   rsp_data_o/rsp_id_o/rsp_val_o/rsp_ready_i : tagged response.
// Build option: POPCNT_ARB_FIXED_PRIO_EN selects fixed priority (lowest index).
module popcnt_arbiter #(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH) + 1,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk_i,
   input  logic                   arst_n_i,
   input  logic [N_REQ*WIDTH-1:0] req_data_i,
   input  logic [N_REQ-1:0]       req_val_i,
   output logic [N_REQ-1:0]       req_ready_o,
   output logic [WIDTH-1:0]       pc_data_o,
   output logic                   pc_data_val_o,
   input  logic [CNT_W-1:0]       pc_data_i,
   input  logic                   pc_data_val_i,
   output logic [CNT_W-1:0]       rsp_data_o,
   output logic [ID_W-1:0]        rsp_id_o,
   output logic                   rsp_val_o,
   input  logic                   rsp_ready_i
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   state_e           st_q, st_d;
   logic [WIDTH-1:0] pc_data_q, pc_data_d;
   logic             pc_val_q, pc_val_d;
   logic [CNT_W-1:0] rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic             rsp_val_q, rsp_val_d;

   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_vld;
   logic             hs;

   // A grant in IDLE is a handshake by construction: ready mirrors val.
   assign hs = (st_q == IDLE) && gnt_vld;

`ifdef POPCNT_ARB_FIXED_PRIO_EN
   // Descending scan so the lowest valid index is written last.
   always_comb begin : gnt_c
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_val_i[i]) begin
            gnt_idx = ID_W'(i);
            gnt_vld = 1'b1;
         end
      end
   end
`else
   logic [ID_W-1:0] rr_q, rr_d;

   // Descending scan over offsets from rr_q; the smallest offset wins.
   always_comb begin : gnt_c
      int k;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      k       = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k = (int'(rr_q) + i) % N_REQ;
         if (req_val_i[k]) begin
            gnt_idx = ID_W'(k);
            gnt_vld = 1'b1;
         end
      end
   end

   always_comb begin : rr_c
      rr_d = rr_q;
      if (hs) begin
         if (gnt_idx == ID_W'(N_REQ - 1)) rr_d = '0;
         else                             rr_d = gnt_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) rr_q <= '0;
      else           rr_q <= rr_d;
   end
`endif

   // Ready is forced low while reset is held.
   always_comb begin : rdy_c
      req_ready_o = '0;
      if (hs && arst_n_i) req_ready_o[gnt_idx] = 1'b1;
   end

   always_comb begin : fsm_c
      st_d       = st_q;
      pc_data_d  = pc_data_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      unique case (st_q)
         IDLE: begin
            if (hs) begin
               pc_data_d = req_data_i[int'(gnt_idx)*WIDTH +: WIDTH];
               rsp_id_d  = gnt_idx;
               st_d      = ISSUE;
            end
         end
         ISSUE: st_d = WAIT;
         WAIT: begin
            if (pc_data_val_i) begin
               rsp_data_d = pc_data_i;
               st_d       = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) st_d = IDLE;
         end
      endcase
      // Valid flags registered from the next state keep them glitch-free.
      pc_val_d  = (st_d == ISSUE);
      rsp_val_d = (st_d == RESP);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         st_q       <= IDLE;
         pc_data_q  <= '0;
         pc_val_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rsp_val_q  <= 1'b0;
      end else begin
         st_q       <= st_d;
         pc_data_q  <= pc_data_d;
         pc_val_q   <= pc_val_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_val_q  <= rsp_val_d;
      end
   end

   assign pc_data_o     = pc_data_q;
   assign pc_data_val_o = pc_val_q;
   assign rsp_data_o    = rsp_data_q;
   assign rsp_id_o      = rsp_id_q;
   assign rsp_val_o     = rsp_val_q;

endmodule

// File: tb/tb_popcnt_arbiter.sv
// tb_popcnt_arbiter: directed bench for popcnt_arbiter with a
// behavioural engine of programmable latency and spurious-valid injection.
module tb_popcnt_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int CW = 5;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           arst_n_i;
   logic [N*W-1:0] req_data_i;
   logic [N-1:0]   req_val_i;
   logic [N-1:0]   req_ready_o;
   logic [W-1:0]   pc_data_o;
   logic           pc_data_val_o;
   logic [CW-1:0]  pc_data_i;
   logic           pc_data_val_i;
   logic [CW-1:0]  rsp_data_o;
   logic [IW-1:0]  rsp_id_o;
   logic           rsp_val_o;
   logic           rsp_ready_i;

   logic           eng_val  = 1'b0;
   logic [CW-1:0]  eng_data = '0;
   logic           spur_val = 1'b0;
   logic [CW-1:0]  spur_data = '0;
   int             eng_lat  = 1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] data;
      logic [4:0]  cnt;
   } vec_t;

   vec_t tbl [7];

   popcnt_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk_i         (clk),
      .arst_n_i      (arst_n_i),
      .req_data_i    (req_data_i),
      .req_val_i     (req_val_i),
      .req_ready_o   (req_ready_o),
      .pc_data_o     (pc_data_o),
      .pc_data_val_o (pc_data_val_o),
      .pc_data_i     (pc_data_i),
      .pc_data_val_i (pc_data_val_i),
      .rsp_data_o    (rsp_data_o),
      .rsp_id_o      (rsp_id_o),
      .rsp_val_o     (rsp_val_o),
      .rsp_ready_i   (rsp_ready_i)
   );

   always #5 clk = ~clk;

   assign pc_data_val_i = eng_val | spur_val;
   assign pc_data_i     = spur_val ? spur_data : eng_data;

   // Engine stub: answers eng_lat cycles after the issue pulse.
   always begin
      @(negedge clk);
      if (pc_data_val_o) begin
         eng_data = CW'($countones(pc_data_o));
         repeat (eng_lat) @(posedge clk);
         #1 eng_val = 1'b1;
         @(posedge clk);
         #1 eng_val = 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  nm, $time, act, exp);
      end
   endtask

   task automatic wait_hs(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         #1;
         if (|(req_ready_o & req_val_i)) ok = 1'b1;
         else @(negedge clk);
      end
      chk("handshake", 32'(ok), 1);
   endtask

   // Called at a negedge with requests set up; returns at the negedge
   // after completion (FSM back in IDLE).
   task automatic serve(input int id, input logic [15:0] data,
                        input int cnt, input int lat, input bit drop,
                        input int bp, input bit spur_iss,
                        input bit spur_rsp);
      bit ok;
      wait_hs(ok);
      if (!ok) return;
      chk("grant", 32'(req_ready_o), 32'(1) << id);
      @(negedge clk);
      if (drop) req_val_i[id] = 1'b0;
      if (spur_iss) begin
         spur_data = 5'h1F;
         spur_val  = 1'b1;
      end
      #1;
      chk("pc_val_issue", 32'(pc_data_val_o), 1);
      chk("pc_data", 32'(pc_data_o), 32'(data));
      chk("ready_issue", 32'(req_ready_o), 0);
      @(negedge clk);
      spur_val = 1'b0;
      chk("pc_val_pulse", 32'(pc_data_val_o), 0);
      for (int j = 0; j < lat; j++) begin
         chk("rsp_val_early", 32'(rsp_val_o), 0);
         @(negedge clk);
      end
      chk("rsp_val", 32'(rsp_val_o), 1);
      chk("rsp_data", 32'(rsp_data_o), 32'(cnt));
      chk("rsp_id", 32'(rsp_id_o), 32'(id));
      if (bp > 0) begin
         rsp_ready_i = 1'b0;
         for (int i = 0; i < bp; i++) begin
            req_val_i = '1;
            if (spur_rsp && i == 0) begin
               spur_data = 5'h1F;
               spur_val  = 1'b1;
            end
            if (i == 1) spur_val = 1'b0;
            #1;
            chk("bp_val", 32'(rsp_val_o), 1);
            chk("bp_data", 32'(rsp_data_o), 32'(cnt));
            chk("bp_id", 32'(rsp_id_o), 32'(id));
            chk("bp_ready", 32'(req_ready_o), 0);
            @(negedge clk);
         end
         spur_val    = 1'b0;
         req_val_i   = '0;
         rsp_ready_i = 1'b1;
      end
      @(negedge clk);
      chk("rsp_done", 32'(rsp_val_o), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int exp_order [6];
`ifdef POPCNT_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0, 1};
`endif
      tbl[0] = '{2'd2, 16'hF0F0, 5'd8};
      tbl[1] = '{2'd0, 16'hFFFF, 5'd16};
      tbl[2] = '{2'd1, 16'h0000, 5'd0};
      tbl[3] = '{2'd3, 16'h8001, 5'd2};
      tbl[4] = '{2'd0, 16'h1234, 5'd5};
      tbl[5] = '{2'd1, 16'hAAAA, 5'd8};
      tbl[6] = '{2'd3, 16'h7FFF, 5'd15};

      // Reset state, with all requesters valid.
      arst_n_i    = 1'b0;
      req_data_i  = '0;
      req_val_i   = '1;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_ready", 32'(req_ready_o), 0);
      chk("rst_pc_data", 32'(pc_data_o), 0);
      chk("rst_pc_val", 32'(pc_data_val_o), 0);
      chk("rst_rsp_data", 32'(rsp_data_o), 0);
      chk("rst_rsp_id", 32'(rsp_id_o), 0);
      chk("rst_rsp_val", 32'(rsp_val_o), 0);
      @(negedge clk);
      req_val_i = '0;
      arst_n_i  = 1'b1;
      @(negedge clk);

      // Single requests from the table.
      for (int i = 0; i < 7; i++) begin
         req_data_i[int'(tbl[i].id)*W +: W] = tbl[i].data;
         req_val_i = 4'b0001 << tbl[i].id;
         serve(int'(tbl[i].id), tbl[i].data, int'(tbl[i].cnt),
               1, 1'b1, 0, 1'b0, 1'b0);
      end

      // Reset in the middle of WAIT with a slow engine.
      eng_lat = 5;
      req_data_i[1*W +: W] = 16'h1111;
      req_val_i = 4'b0010;
      wait_hs(ok);
      @(negedge clk);
      req_val_i = '0;
      @(negedge clk);
      @(negedge clk);
      arst_n_i  = 1'b0;
      req_val_i = '1;
      #1;
      chk("mid_rst_ready", 32'(req_ready_o), 0);
      chk("mid_rst_pc_data", 32'(pc_data_o), 0);
      chk("mid_rst_pc_val", 32'(pc_data_val_o), 0);
      chk("mid_rst_rsp_data", 32'(rsp_data_o), 0);
      chk("mid_rst_rsp_id", 32'(rsp_id_o), 0);
      chk("mid_rst_rsp_val", 32'(rsp_val_o), 0);
      repeat (6) @(negedge clk);
      req_val_i = '0;
      arst_n_i  = 1'b1;
      eng_lat   = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stale_rsp_val", 32'(rsp_val_o), 0);
         chk("stale_pc_val", 32'(pc_data_val_o), 0);
      end
      req_data_i[3*W +: W] = 16'hFFFF;
      req_val_i = 4'b1000;
      serve(3, 16'hFFFF, 16, 1, 1'b1, 0, 1'b0, 1'b0);

      // Fairness: all four requesters valid continuously.
      for (int k = 0; k < N; k++)
         req_data_i[k*W +: W] = 16'((32'd1 << (k + 1)) - 1);
      req_val_i = '1;
      for (int i = 0; i < 6; i++)
         serve(exp_order[i], 16'((32'd1 << (exp_order[i] + 1)) - 1),
               exp_order[i] + 1, 1, 1'b0, 0, 1'b0, 1'b0);
      req_val_i = '0;

      // Backpressure: response held for 10 cycles.
      req_data_i[1*W +: W] = 16'h00FF;
      req_val_i = 4'b0010;
      serve(1, 16'h00FF, 8, 1, 1'b1, 10, 1'b0, 1'b0);

      // Spurious engine valid in IDLE, then slow engine with more.
      spur_data = 5'h1F;
      spur_val  = 1'b1;
      @(negedge clk);
      spur_val = 1'b0;
      chk("spur_idle_rsp", 32'(rsp_val_o), 0);
      chk("spur_idle_pc", 32'(pc_data_val_o), 0);
      @(negedge clk);
      chk("spur_idle_rsp2", 32'(rsp_val_o), 0);
      eng_lat = 5;
      req_data_i[2*W +: W] = 16'h0F0F;
      req_val_i = 4'b0100;
      serve(2, 16'h0F0F, 8, 5, 1'b1, 2, 1'b1, 1'b1);
      eng_lat = 1;

      // Pointer wrap: 3 alone, then 0 and 3 together.
      req_data_i[0*W +: W] = 16'h0101;
      req_data_i[3*W +: W] = 16'hFFFE;
      req_val_i = 4'b1000;
      serve(3, 16'hFFFE, 15, 1, 1'b1, 0, 1'b0, 1'b0);
      req_val_i = 4'b1001;
      serve(0, 16'h0101, 2, 1, 1'b1, 0, 1'b0, 1'b0);
      serve(3, 16'hFFFE, 15, 1, 1'b1, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/popcnt_arbiter.md
# popcnt_arbiter

- Shares one `bit_population_counter` engine between `N_REQ` requesters using round-robin arbitration.
- Each request is a `WIDTH`-bit word carried on a valid/ready handshake.
- The block issues the winning word to the engine as a single-cycle valid pulse, waits for the count, then returns it tagged with the requester index.
- It sits between the client ports and the engine instance; the engine itself is external.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 16: data word width; must match the engine.
- `CNT_W`: count width, fixed at `$clog2(WIDTH)+1`.
- `ID_W`: requester index width, `$clog2(N_REQ)`.

Ports:
- `clk_i`  in  1  clock.
- `arst_n_i`  in  1  reset. Asynchronous, active-low.
- `req_data_i`  in  N_REQ*WIDTH  request words; requester k occupies bits [k*WIDTH +: WIDTH].
- `req_val_i`  in  N_REQ  per-requester valid.
- `req_ready_o`  out  N_REQ  per-requester ready; at most one bit is high.
- `pc_data_o`  out  WIDTH  word to the engine.
- `pc_data_val_o`  out  1  engine input valid; single-cycle pulse.
- `pc_data_i`  in  CNT_W  engine count.
- `pc_data_val_i`  in  1  engine output valid.
- `rsp_data_o`  out  CNT_W  returned count.
- `rsp_id_o`  out  ID_W  index of the requester that owns `rsp_data_o`.
- `rsp_val_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accepted.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `grant` is the first requester with `req_val_i` high, searching from `rr_ptr` upward and wrapping modulo `N_REQ`.
  - `req_ready_o = grant`, combinational, driven only in IDLE.
  - On handshake (val && ready): register the word into `pc_data_o`, register the index into `rsp_id_o`, set `rr_ptr` to (granted index + 1) mod `N_REQ`, go to ISSUE.
  - With no valid requests: stay in IDLE; `rr_ptr` is unchanged.
- **ISSUE**
  - `pc_data_val_o` is 1 for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - On `pc_data_val_i`: register `pc_data_i` into `rsp_data_o`, go to RESP.
  - There is no timeout; the block waits indefinitely.
- **RESP**
  - `rsp_val_o` is 1.
  - Hold `rsp_data_o` and `rsp_id_o` stable until `rsp_ready_i`, then go to IDLE.
- Boundary rules:
  - `pc_data_val_i` is ignored outside WAIT.
  - `pc_data_val_i` arriving in the same cycle as ISSUE is ignored; the engine minimum latency is 1.
  - `req_val_i` changing outside IDLE has no effect, since all ready bits are 0.
  - `req_val_i` dropping in IDLE before a handshake causes no state change.
  - `rsp_ready_i` outside RESP is ignored.
- The one request in flight is the only buffering; no new request is accepted until the response is consumed.
- Widths:
  - Counts pass through unmodified.
  - All-ones input returns `WIDTH` (e.g. 16 = 5'b10000).
  - All-zero input returns 0.

## Timing
- Reset (async assert, sync-released by the top level):
  - FSM state = IDLE, `rr_ptr` = 0.
  - `pc_data_o` = 0, `pc_data_val_o` = 0.
  - `rsp_data_o` = 0, `rsp_id_o` = 0, `rsp_val_o` = 0.
  - `req_ready_o` = 0 while reset is asserted.
- Reset asserted mid-transaction discards the transaction; no response is produced.
- Latency with an engine of latency 1 and `rsp_ready_i` held high:
  - Handshake at cycle T.
  - `pc_data_val_o` at T+1.
  - `pc_data_val_i` at T+2.
  - `rsp_val_o` at T+3.
  - IDLE at T+4; next handshake possible at T+4.
- Peak throughput is 1 request per 4 cycles.
- Output sourcing:
  - `req_ready_o` is combinational from `req_val_i`, `rr_ptr` and state.
  - All other outputs are registered.

## Configuration
- `POPCNT_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest valid index always wins, and `rr_ptr` is not implemented.
  - Undefined (default): round-robin as described in Operation.
- `rsp_id_o` and the latency are identical in both builds.

## Test plan
- **Reset:**
  - Stimulus: `arst_n_i` low mid-WAIT.
  - Required: every output is 0 in the same cycle. After release, a fresh request completes normally and no stale `rsp_val_o` appears.
- **Single request:**
  - Stimulus: req 2, data 16'hF0F0, `rsp_ready_i` = 1.
  - Required: `pc_data_o` = 16'hF0F0 with a pulse at T+1; `rsp_data_o` = 8 and `rsp_id_o` = 2 at T+3. Values 16'hFFFF → 16 and 16'h0000 → 0 are also checked.
- **Round-robin fairness:**
  - Stimulus: all 4 requesters valid continuously.
  - Required: grant order is 0,1,2,3,0,1; no requester is granted twice before the others. With `POPCNT_ARB_FIXED_PRIO_EN` the order is 0,0,0,...
- **Backpressure:**
  - Stimulus: `rsp_ready_i` = 0 for 10 cycles during RESP.
  - Required: `rsp_val_o`, data and id stay stable; all `req_ready_o` bits stay 0; completion occurs one cycle after `rsp_ready_i` rises.
- **Slow engine / spurious valid:**
  - Stimulus: the engine responds after 5 cycles, and `pc_data_val_i` is pulsed during IDLE and RESP.
  - Required: the response carries the 5-cycle result; the spurious pulses change nothing.
- **Pointer wrap:**
  - Stimulus: only requester 3 is valid, then requesters 0 and 3 together.
  - Required: 3 is served first, then 0 (pointer wraps 3→0), then 3.
